sm_motor_ramp: RTL and testbench

- Upstream command stage for the two-motor PWM generator.
- Accepts a direction plus target-speed command per motor (right = A1, left = B1).
- Slews each motor's speed toward its target at a fixed rate. Direction reversal is always decelerate, then dead-time, then accelerate, so the H-bridge never sees an abrupt reversal.
- Drives the four 7-bit duty inputs (speed_a1_a/a1_b/b1_a/b1_b) of the PWM stage, full scale 0..100.

---
 rtl/sm_motor_pkg.sv | 23 ++
 rtl/sm_ramp_channel.sv | 145 ++++++++++++++
 rtl/sm_motor_ramp.sv | 133 +++++++++++++
 tb/tb_sm_motor_ramp.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sm_motor_pkg.sv
// Shared types and constants for the two-motor ramp command stage.
// Speeds are 0..MAX_SPEED duty units; ramp math is done 8-bit wide.
package sm_motor_pkg;

  localparam int   MAX_SPEED = 100;
  localparam int   SPEED_W   = 7;
  localparam logic DIR_FWD   = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DECEL,
    DEAD
  } ch_state_e;

  function automatic logic [7:0] min8(
    input logic [7:0] a,
    input logic [7:0] b
  );
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/sm_ramp_channel.sv
// One motor channel: command latch, ramp FSM, speed register, dead timer.
// Optional SM_MOTOR_ESTOP_EN adds an estop input that parks the channel.
module sm_ramp_channel
  import sm_motor_pkg::*;
#(
  parameter int STEP     = 2,
  parameter int DEAD_CYC = 500000
) (
  input  logic               clk,
  input  logic               rst,
`ifdef SM_MOTOR_ESTOP_EN
  input  logic               estop,
`endif
  input  logic               tick,
  input  logic               cmd_valid,
  input  logic               cmd_dir,
  input  logic [SPEED_W-1:0] cmd_speed,
  output logic [SPEED_W-1:0] cur,
  output logic               cur_dir,
  output logic               busy
);

  localparam int DW = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
  localparam logic [DW-1:0] DEAD_LD = DW'(DEAD_CYC - 1);
  localparam logic [7:0] STEP8 = 8'(STEP);
  localparam logic [7:0] MAX8  = 8'(MAX_SPEED);

  ch_state_e          state_q, state_d;
  logic [SPEED_W-1:0] cur_q, cur_d;
  logic [SPEED_W-1:0] tgt_q, tgt_d;
  logic               tgt_dir_q, tgt_dir_d;
  logic               cur_dir_q, cur_dir_d;
  logic [DW-1:0]      dead_q, dead_d;

  logic [7:0] cur8;
  logic [7:0] tgt8;
  logic [7:0] nxt8;

  assign cur8 = {1'b0, cur_q};
  assign tgt8 = {1'b0, tgt_q};

  always_comb begin
    state_d   = state_q;
    tgt_d     = tgt_q;
    tgt_dir_d = tgt_dir_q;
    cur_dir_d = cur_dir_q;
    dead_d    = dead_q;
    nxt8      = cur8;

    if (cmd_valid) begin
      tgt_d     = SPEED_W'(min8({1'b0, cmd_speed}, MAX8));
      tgt_dir_d = cmd_dir;
    end

    // The FSM always sees the previously latched target.
    unique case (state_q)
      IDLE: begin
        nxt8 = 8'd0;
        if (tgt_q != '0) begin
          cur_dir_d = tgt_dir_q;
          state_d   = RUN;
        end
      end
      RUN: begin
        if (tgt_dir_q != cur_dir_q) begin
          state_d = DECEL;
        end else begin
          if (tick) begin
            if (cur8 < tgt8)
              nxt8 = cur8 + min8(tgt8 - cur8, STEP8);
            else if (cur8 > tgt8)
              nxt8 = cur8 - min8(cur8 - tgt8, STEP8);
          end
          if (nxt8 == 8'd0 && tgt_q == '0)
            state_d = IDLE;
        end
      end
      DECEL: begin
        if (tgt_dir_q == cur_dir_q) begin
          state_d = RUN;
        end else begin
          if (tick)
            nxt8 = cur8 - min8(cur8, STEP8);
          if (nxt8 == 8'd0) begin
            dead_d  = DEAD_LD;
            state_d = DEAD;
          end
        end
      end
      DEAD: begin
        nxt8 = 8'd0;
        if (dead_q == '0) begin
          cur_dir_d = tgt_dir_q;
          state_d   = (tgt_q != '0) ? RUN : IDLE;
        end else begin
          dead_d = dead_q - DW'(1);
        end
      end
      default: begin
        nxt8    = 8'd0;
        state_d = IDLE;
      end
    endcase

`ifdef SM_MOTOR_ESTOP_EN
    if (estop) begin
      nxt8    = 8'd0;
      tgt_d   = '0;
      state_d = IDLE;
    end
`endif

    cur_d = nxt8[SPEED_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cur_q     <= '0;
      tgt_q     <= '0;
      tgt_dir_q <= DIR_FWD;
      cur_dir_q <= DIR_FWD;
      dead_q    <= '0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      tgt_q     <= tgt_d;
      tgt_dir_q <= tgt_dir_d;
      cur_dir_q <= cur_dir_d;
      dead_q    <= dead_d;
    end
  end

  assign cur     = cur_q;
  assign cur_dir = cur_dir_q;

  // Idle with no target counts as settled.
  always_comb begin
    if (state_q == RUN)
      busy = (cur_q != tgt_q) || (tgt_dir_q != cur_dir_q);
    else
      busy = !(state_q == IDLE && tgt_q == '0);
  end

endmodule

// File: rtl/sm_motor_ramp.sv
// Two-motor ramp stage: shared tick prescaler and registered duty mapping.
// Define SM_MOTOR_ESTOP_EN to add the estop input.
module sm_motor_ramp
  import sm_motor_pkg::*;
#(
  parameter int RAMP_DIV = 50000,
  parameter int STEP     = 2,
  parameter int DEAD_CYC = 500000
) (
  input  logic       clk,
  input  logic       rst,
`ifdef SM_MOTOR_ESTOP_EN
  input  logic       estop,
`endif
  input  logic       cmd_valid_a,
  input  logic       cmd_dir_a,
  input  logic [6:0] cmd_speed_a,
  input  logic       cmd_valid_b,
  input  logic       cmd_dir_b,
  input  logic [6:0] cmd_speed_b,
  output logic [6:0] speed_a1_a,
  output logic [6:0] speed_a1_b,
  output logic [6:0] speed_b1_a,
  output logic [6:0] speed_b1_b,
  output logic       busy_a,
  output logic       busy_b
);

  localparam int PW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [PW-1:0] PS_MAX = PW'(RAMP_DIV - 1);

  logic [PW-1:0] ps_q, ps_d;
  logic          tick;

  logic [SPEED_W-1:0] cur_a, cur_b;
  logic               dir_a, dir_b;
  logic               bsy_a, bsy_b;

  logic [6:0] a1_a_q, a1_a_d;
  logic [6:0] a1_b_q, a1_b_d;
  logic [6:0] b1_a_q, b1_a_d;
  logic [6:0] b1_b_q, b1_b_d;
  logic       busy_a_q, busy_a_d;
  logic       busy_b_q, busy_b_d;

  assign tick = (ps_q == PS_MAX);

  always_comb begin
    ps_d = tick ? '0 : ps_q + PW'(1);
  end

  sm_ramp_channel #(
    .STEP     (STEP),
    .DEAD_CYC (DEAD_CYC)
  ) u_ch_a (
    .clk       (clk),
    .rst       (rst),
`ifdef SM_MOTOR_ESTOP_EN
    .estop     (estop),
`endif
    .tick      (tick),
    .cmd_valid (cmd_valid_a),
    .cmd_dir   (cmd_dir_a),
    .cmd_speed (cmd_speed_a),
    .cur       (cur_a),
    .cur_dir   (dir_a),
    .busy      (bsy_a)
  );

  sm_ramp_channel #(
    .STEP     (STEP),
    .DEAD_CYC (DEAD_CYC)
  ) u_ch_b (
    .clk       (clk),
    .rst       (rst),
`ifdef SM_MOTOR_ESTOP_EN
    .estop     (estop),
`endif
    .tick      (tick),
    .cmd_valid (cmd_valid_b),
    .cmd_dir   (cmd_dir_b),
    .cmd_speed (cmd_speed_b),
    .cur       (cur_b),
    .cur_dir   (dir_b),
    .busy      (bsy_b)
  );

  // Only one leg of each bridge is ever driven.
  always_comb begin
    a1_a_d   = (dir_a == DIR_FWD) ? cur_a : '0;
    a1_b_d   = (dir_a == DIR_FWD) ? '0 : cur_a;
    b1_a_d   = (dir_b == DIR_FWD) ? cur_b : '0;
    b1_b_d   = (dir_b == DIR_FWD) ? '0 : cur_b;
    busy_a_d = bsy_a;
    busy_b_d = bsy_b;
`ifdef SM_MOTOR_ESTOP_EN
    if (estop) begin
      a1_a_d = '0;
      a1_b_d = '0;
      b1_a_d = '0;
      b1_b_d = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ps_q     <= '0;
      a1_a_q   <= '0;
      a1_b_q   <= '0;
      b1_a_q   <= '0;
      b1_b_q   <= '0;
      busy_a_q <= 1'b0;
      busy_b_q <= 1'b0;
    end else begin
      ps_q     <= ps_d;
      a1_a_q   <= a1_a_d;
      a1_b_q   <= a1_b_d;
      b1_a_q   <= b1_a_d;
      b1_b_q   <= b1_b_d;
      busy_a_q <= busy_a_d;
      busy_b_q <= busy_b_d;
    end
  end

  assign speed_a1_a = a1_a_q;
  assign speed_a1_b = a1_b_q;
  assign speed_b1_a = b1_a_q;
  assign speed_b1_b = b1_b_q;
  assign busy_a     = busy_a_q;
  assign busy_b     = busy_b_q;

endmodule

// File: tb/tb_sm_motor_ramp.sv
// Scoreboard bench for sm_motor_ramp: expected duty changes are queued
// by the stimulus and popped by a monitor whenever a duty output moves.
module tb_sm_motor_ramp;

  localparam int RAMP_DIV = 4;
  localparam int STEP     = 5;
  localparam int DEAD_CYC = 8;

  logic       clk = 1'b0;
  logic       rst;
`ifdef SM_MOTOR_ESTOP_EN
  logic       estop;
`endif
  logic       cmd_valid_a, cmd_dir_a;
  logic [6:0] cmd_speed_a;
  logic       cmd_valid_b, cmd_dir_b;
  logic [6:0] cmd_speed_b;
  logic [6:0] speed_a1_a, speed_a1_b, speed_b1_a, speed_b1_b;
  logic       busy_a, busy_b;

  always #5 clk = ~clk;

  sm_motor_ramp #(
    .RAMP_DIV (RAMP_DIV),
    .STEP     (STEP),
    .DEAD_CYC (DEAD_CYC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
`ifdef SM_MOTOR_ESTOP_EN
    .estop       (estop),
`endif
    .cmd_valid_a (cmd_valid_a),
    .cmd_dir_a   (cmd_dir_a),
    .cmd_speed_a (cmd_speed_a),
    .cmd_valid_b (cmd_valid_b),
    .cmd_dir_b   (cmd_dir_b),
    .cmd_speed_b (cmd_speed_b),
    .speed_a1_a  (speed_a1_a),
    .speed_a1_b  (speed_a1_b),
    .speed_b1_a  (speed_b1_a),
    .speed_b1_b  (speed_b1_b),
    .busy_a      (busy_a),
    .busy_b      (busy_b)
  );

  logic [6:0] duty [4];
  assign duty[0] = speed_a1_a;
  assign duty[1] = speed_a1_b;
  assign duty[2] = speed_b1_a;
  assign duty[3] = speed_b1_b;

  logic [6:0] expq [4][$];
  logic [6:0] prev [4];
  logic [6:0] mon_e;
  string      names [4] = '{"a1_a", "a1_b", "b1_a", "b1_b"};
  int         checks = 0;
  int         errors = 0;
  bit         mon_en = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic push(input int i, input int v);
    expq[i].push_back(7'(v));
  endtask

  // Monitor: every change on a duty output must match the queue head.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int i = 0; i < 4; i++) begin
        if (duty[i] !== prev[i]) begin
          checks++;
          if (expq[i].size() == 0) begin
            errors++;
            $display("FAIL %s: unexpected change to %0d", names[i], duty[i]);
          end else begin
            mon_e = expq[i].pop_front();
            if (duty[i] !== mon_e) begin
              errors++;
              $display("FAIL %s: got %0d expected %0d", names[i], duty[i], mon_e);
            end
          end
          prev[i] = duty[i];
        end
      end
      checks++;
      if ((speed_a1_a != 0 && speed_a1_b != 0) ||
          (speed_b1_a != 0 && speed_b1_b != 0)) begin
        errors++;
        $display("FAIL bridge_excl: a1 %0d/%0d b1 %0d/%0d",
                 speed_a1_a, speed_a1_b, speed_b1_a, speed_b1_b);
      end
    end
  end

  task automatic send_a(input logic dir, input int spd);
    cmd_valid_a = 1'b1;
    cmd_dir_a   = dir;
    cmd_speed_a = 7'(spd);
    @(negedge clk);
    cmd_valid_a = 1'b0;
  endtask

  task automatic wait_settle(input int ch);
    int n;
    n = 0;
    repeat (3) @(negedge clk);
    while (((ch == 0) ? busy_a : busy_b) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      checks++;
      errors++;
      $display("FAIL settle_timeout: channel %0d still busy", ch);
    end
  endtask

  task automatic wait_val(input int i, input int v);
    int n;
    n = 0;
    while (duty[i] !== 7'(v) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL wait_%s: got %0d waiting for %0d", names[i], duty[i], v);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int g;
    rst         = 1'b1;
`ifdef SM_MOTOR_ESTOP_EN
    estop       = 1'b0;
`endif
    cmd_valid_a = 1'b0;
    cmd_dir_a   = 1'b1;
    cmd_speed_a = '0;
    cmd_valid_b = 1'b0;
    cmd_dir_b   = 1'b1;
    cmd_speed_b = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) prev[i] = 7'd0;
    mon_en = 1'b1;

    chk("rst_a1_a", speed_a1_a, 0);
    chk("rst_a1_b", speed_a1_b, 0);
    chk("rst_b1_a", speed_b1_a, 0);
    chk("rst_b1_b", speed_b1_b, 0);
    chk("rst_busy_a", busy_a, 0);
    chk("rst_busy_b", busy_b, 0);

    // Reset again with the prescaler mid-count.
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst2_busy_a", busy_a, 0);

    push(0, 5); push(0, 10); push(0, 15); push(0, 20); push(0, 23);
    rst         = 1'b0;
    cmd_valid_a = 1'b1;
    cmd_dir_a   = 1'b1;
    cmd_speed_a = 7'd23;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      cmd_valid_a = 1'b0;
    end while (speed_a1_a == 0 && n < 20);
    chk("first_step_latency", n, 5);
    wait_settle(0);
    chk("fwd23_a1_a", speed_a1_a, 23);
    chk("fwd23_busy_a", busy_a, 0);

    push(0, 20);
    send_a(1'b1, 20);
    wait_settle(0);
    chk("fwd20_a1_a", speed_a1_a, 20);

    // Reversal: decel, dead-time, then accelerate the other leg.
    push(0, 15); push(0, 10); push(0, 5); push(0, 0);
    push(1, 5); push(1, 10);
    send_a(1'b0, 10);
    wait_val(0, 0);
    g = 0;
    while (speed_a1_b == 0 && g < 200) begin
      @(negedge clk);
      g++;
    end
    checks++;
    if (g < DEAD_CYC + 1 || g > DEAD_CYC + RAMP_DIV + 1) begin
      errors++;
      $display("FAIL dead_gap: got %0d cycles expected %0d..%0d",
               g, DEAD_CYC + 1, DEAD_CYC + RAMP_DIV + 1);
    end
    wait_settle(0);
    chk("rev10_a1_b", speed_a1_b, 10);

    push(1, 15); push(1, 20);
    send_a(1'b0, 20);
    wait_settle(0);

    // Abort a deceleration at 10 by restoring the original direction.
    push(1, 15); push(1, 10);
    send_a(1'b1, 5);
    wait_val(1, 10);
    push(1, 15); push(1, 20); push(1, 25); push(1, 30);
    send_a(1'b0, 30);
    wait_settle(0);
    chk("abort_a1_b", speed_a1_b, 30);

    for (int v = 35; v <= 100; v += 5) push(1, v);
    send_a(1'b0, 120);
    wait_settle(0);
    chk("clamp_a1_b", speed_a1_b, 100);
    chk("clamp_busy_a", busy_a, 0);

    push(1, 95);
    send_a(1'b0, 50);
    wait_val(1, 95);
    push(1, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_ramp_a1_b", speed_a1_b, 0);
    chk("rst_ramp_busy_a", busy_a, 0);
    rst = 1'b0;
    repeat (12) @(negedge clk);

    for (int v = 5; v <= 50; v += 5) push(0, v);
    for (int v = 5; v <= 40; v += 5) push(3, v);
    cmd_valid_a = 1'b1; cmd_dir_a = 1'b1; cmd_speed_a = 7'd50;
    cmd_valid_b = 1'b1; cmd_dir_b = 1'b0; cmd_speed_b = 7'd40;
    @(negedge clk);
    cmd_valid_a = 1'b0;
    cmd_valid_b = 1'b0;
    wait_val(0, 5);
    chk("same_tick_b1_b", speed_b1_b, 5);
    wait_settle(0);
    wait_settle(1);
    chk("dual_a1_a", speed_a1_a, 50);
    chk("dual_b1_b", speed_b1_b, 40);
    chk("dual_busy_b", busy_b, 0);

`ifdef SM_MOTOR_ESTOP_EN
    push(0, 0);
    push(3, 0);
    estop = 1'b1;
    @(negedge clk);
    chk("estop_a1_a", speed_a1_a, 0);
    chk("estop_b1_b", speed_b1_b, 0);
    send_a(1'b1, 30);
    repeat (10) @(negedge clk);
    estop = 1'b0;
    repeat (10) @(negedge clk);
    chk("estop_hold_a1_a", speed_a1_a, 0);
    push(0, 5); push(0, 10);
    send_a(1'b1, 10);
    wait_settle(0);
    chk("estop_restart_a1_a", speed_a1_a, 10);
`endif

    repeat (6) @(negedge clk);
    for (int i = 0; i < 4; i++)
      chk({"drain_", names[i]}, expq[i].size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
